// File: rtl/uart_pkg.sv
// Shared types and helpers for the extended UART receiver.
package uart_pkg;

    // states: IDLE wait for fall | START verify start | DATA shift | PARITY check | STOP stop bits | BREAK_WAIT line held low
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one-clk pulse every CLK_FREQ/(BAUD*OVERSAMPLING) clocks.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD         = 115200,
    parameter int OVERSAMPLING = 16
)(
    input  logic clk,
    input  logic rst,
    output logic o_tick
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLING);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CNT_W   = clog2(DIV + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= CNT_W'(DIV - 1);
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == '0);
            if (r_cnt == '0) r_cnt <= CNT_W'(DIV - 1);
            else             r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; a pop frees room for a same-cycle push.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || i_pop);
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ext.sv
// Oversampled UART receiver with per-character error flags, break/idle detection and a FWFT FIFO.
// Parity hardware is built only when UART_RX_PARITY_EN is defined.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD         = 115200,
    parameter int OVERSAMPLING = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_BITS    = 4
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 rx_idle,
    output logic                 rx_eop
);
    localparam int HALF    = OVERSAMPLING / 2;
    localparam int OS_W    = clog2(OVERSAMPLING);
    localparam int BIT_W   = clog2(DATA_BITS);
    localparam int GAP_MAX = IDLE_BITS * OVERSAMPLING;
    localparam int GAP_W   = clog2(GAP_MAX + 1);
`ifdef UART_RX_PARITY_EN
    localparam int FIFO_W    = DATA_BITS + 2;
    localparam bit PAR_ON    = (PARITY != PAR_NONE);
    localparam bit PAR_ODD_M = (PARITY == PAR_ODD);
`else
    localparam int FIFO_W    = DATA_BITS + 1;
    // PARITY is accepted for interface compatibility but has no effect here.
    if (PARITY != PAR_NONE) begin : g_parity_ignored
    end
`endif

    logic                 w_tick;
    logic [1:0]           r_sync;
    logic [2:0]           r_samp;
    logic                 r_filt_prev;
    logic                 w_filt;
    logic                 w_fall;
    logic                 w_sample;
    logic                 w_par_low;
    logic                 w_break;

    rx_state_e            r_state;
    logic [OS_W-1:0]      r_os_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_err;
    logic                 r_push;
    logic [FIFO_W-1:0]    r_push_data;
    logic                 r_break;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic                 r_idle;
    logic                 r_eop;
    logic                 r_overrun;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit;
    logic                 r_par_err;
`endif

    logic [FIFO_W-1:0]    w_rdata;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;

    baud_tick_gen #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .OVERSAMPLING (OVERSAMPLING)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= 2'b11;
            r_samp      <= 3'b111;
            r_filt_prev <= 1'b1;
        end else begin
            r_sync      <= {r_sync[0], rx};
            if (w_tick) r_samp <= {r_samp[1:0], r_sync[1]};
            r_filt_prev <= w_filt;
        end
    end

    assign w_filt   = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
    assign w_fall   = r_filt_prev & ~w_filt;
    assign w_sample = w_tick && (r_os_cnt == OS_W'(HALF - 1));

`ifdef UART_RX_PARITY_EN
    assign w_par_low = !PAR_ON || !r_par_bit;
`else
    assign w_par_low = 1'b1;
`endif
    assign w_break = (r_stop_cnt == 1'b0) && (r_shift == '0) && !w_filt && w_par_low;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_break     <= 1'b0;
            r_gap_cnt   <= '0;
            r_idle      <= 1'b0;
            r_eop       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit   <= 1'b0;
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_push  <= 1'b0;
            r_break <= 1'b0;
            r_eop   <= 1'b0;
            if (w_tick) r_os_cnt <= r_os_cnt + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state   <= ST_START;
                        r_os_cnt  <= '0;
                        r_gap_cnt <= '0;
                        r_idle    <= 1'b0;
                    end else if (w_tick && (r_gap_cnt != GAP_W'(GAP_MAX))) begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                        if (r_gap_cnt == GAP_W'(GAP_MAX - 1)) begin
                            r_idle <= 1'b1;
                            r_eop  <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    if (w_sample) begin
                        if (w_filt) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_sample) begin
                        r_shift <= {w_filt, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            r_stop_cnt  <= 1'b0;
                            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            r_par_bit   <= 1'b0;
                            r_par_err   <= 1'b0;
                            r_state     <= PAR_ON ? ST_PARITY : ST_STOP;
`else
                            r_state     <= ST_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_sample) begin
                        r_par_bit <= w_filt;
                        r_par_err <= (^r_shift) ^ w_filt ^ PAR_ODD_M;
                        r_state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_sample) begin
                        if (w_break) begin
                            r_break <= 1'b1;
                            r_state <= ST_BREAK_WAIT;
                        end else if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                            // Back to IDLE right after the last sample so a start bit in the
                            // second half of the stop bit is not missed.
                            r_push  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            r_push_data <= {r_par_err, r_frame_err | ~w_filt, r_shift};
`else
                            r_push_data <= {r_frame_err | ~w_filt, r_shift};
`endif
                            r_state <= ST_IDLE;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                            if (!w_filt) r_frame_err <= 1'b1;
                        end
                    end
                end
                ST_BREAK_WAIT: begin
                    if (w_filt) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_push),
        .i_wdata (r_push_data),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_overrun <= 1'b0;
        else     r_overrun <= r_push && w_full && !w_pop;
    end

    assign valid     = ~w_empty;
    assign w_pop     = valid & ready;
    assign data_out  = w_empty ? '0 : w_rdata[DATA_BITS-1:0];
    assign frame_err = ~w_empty & w_rdata[DATA_BITS];
`ifdef UART_RX_PARITY_EN
    assign parity_err = ~w_empty & w_rdata[DATA_BITS+1];
`else
    assign parity_err = 1'b0;
`endif
    assign overrun   = r_overrun;
    assign break_det = r_break;
    assign rx_idle   = r_idle;
    assign rx_eop    = r_eop;

endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised asynchronous UART receiver, the successor to the fixed 8N1 receiver. It adds configurable character width, optional parity, one or two stop bits, per-character error flags, break detection and a small receive FIFO with a valid/ready output handshake. It sits between the board RX pin and the command parser. It reuses the existing `baud_tick_gen` for oversampling ticks.

## Interface
- CLK_FREQ, 12000000: system clock frequency in Hz.
- BAUD, 115200: line rate.
- OVERSAMPLING, 16: ticks per bit; power of 2, at least 4.
- DATA_BITS, 8: character width, 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: power of 2, at least 2.
- IDLE_BITS, 4: idle bit periods before `rx_idle` asserts.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rx  in  1  serial line, asynchronous, idles high.
- data_out  out  DATA_BITS  character at FIFO head, LSB first on the wire.
- valid  out  1  FIFO non-empty.
- ready  in  1  consumer accepts; a pop occurs when valid && ready.
- frame_err  out  1  head character had a low stop bit; qualified by valid.
- parity_err  out  1  head character failed parity; qualified by valid.
- overrun  out  1  one-cycle pulse when a character is dropped because the FIFO is full.
- break_det  out  1  one-cycle pulse on line break.
- rx_idle  out  1  line idle for at least IDLE_BITS bit periods.
- rx_eop  out  1  one-cycle pulse in the cycle rx_idle rises.

## Operation
- `rx` passes through a 2-flop synchroniser clocked every clk. A 3-sample majority filter samples on os_tick.
- State machine: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE -> START on a filtered high-to-low transition. os_cnt clears to 0.
- Sampling point is os_cnt == OVERSAMPLING/2-1, then every OVERSAMPLING ticks.
- START: if the line is high at the sampling point, the start is false; return to IDLE with no push. Otherwise go to DATA.
- DATA: shifts DATA_BITS samples, LSB first. Then go to PARITY if PARITY != 0, else STOP.
- PARITY: sampled bit is compared against the XOR of the data bits; the odd-parity case inverts the comparison.
- STOP: samples STOP_BITS bits. frame_err is set if any stop bit is low.
- Break condition: data all zero, and the parity and first stop bit both low. Then:
  - Nothing is pushed to the FIFO.
  - break_det pulses.
  - Go to BREAK_WAIT, which exits to IDLE on a filtered high.
- Push timing: {parity_err, frame_err, data} is pushed in the clk cycle after the final stop-bit sample. The FSM returns to IDLE in the same cycle, so a start bit arriving in the second half of the stop bit is caught.
- Push when full with no simultaneous pop: the character is dropped and overrun pulses.
- Push when full with a simultaneous pop: the push is accepted and overrun does not pulse.
- gap_cnt counts os_ticks in IDLE and saturates at IDLE_BITS*OVERSAMPLING. It clears in any other state or in BREAK_WAIT.
- rx_idle = gap_cnt saturated. rx_eop pulses on the saturating tick.

## Timing
- Reset values: valid, data_out, frame_err, parity_err, overrun, break_det, rx_idle and rx_eop are all 0. FIFO is empty, FSM is in IDLE, synchroniser is at 2'b11.
- Reset asserted mid-frame aborts the frame. The partial character is discarded.
- valid rises 1 clk after the push cycle. FIFO is first-word-fall-through, so data_out and the error flags are stable while valid && !ready.
- Pop takes effect at the clock edge. The next entry appears in the same cycle, with no bubble.
- Minimum stop-bit tolerance is half a bit period.
- Line edge to filtered edge: 2 clk plus 2 os_ticks.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined: the PARITY state, parity checker and parity_err FIFO bit are built.
- Undefined:
  - No parity hardware is built.
  - PARITY is ignored and treated as 0.
  - parity_err is tied to 0.
  - FIFO width is DATA_BITS+1.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - Parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
  - clog2 function.
- Sub-module `uart_rx_fifo`:
  - Parametrised first-word-fall-through FIFO (WIDTH, DEPTH).
  - Pointers one bit wider than the address, with wrap-around.
  - full/empty flags, simultaneous push/pop support.
  - Same clk and rst.
- Tick generation reuses the existing `baud_tick_gen`.

## Test plan
- 8N1, send 0xA5, ready=1 -> one valid cycle with data_out=0xA5, frame_err=0, parity_err=0.
- 7E1 (macro on), send 0x03 with parity bit 1 -> data_out=0x03, parity_err=1. Resend with parity bit 0 -> parity_err=0.
- Send 0x55 with stop bit low -> frame_err=1, data_out=0x55. Hold line low for 2 frames -> single break_det pulse, no FIFO push, next 0x12 received cleanly.
- FIFO_DEPTH=4, ready=0, send 0x01..0x05 -> overrun pulses once, on 0x05. Raising ready drains 0x01, 0x02, 0x03, 0x04 on consecutive cycles.
- 1-os_tick low glitch on an idle line -> no valid, no start. 3-tick low pulse -> false start, no push.
- Assert rst during bit 3 of 0x3C -> all outputs 0 immediately. Resend 0x3C after release -> received correctly. Idle for 4 bit periods afterwards -> rx_eop pulses once and rx_idle stays 1.
